// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-entry front end:
// sequencer state encoding, datapath widths and the default debounce length.
package alu_pkg;

  localparam int DATA_W           = 32;
  localparam int OP_W             = 4;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    S_WAIT_A = 2'd0,
    S_WAIT_B = 2'd1,
    S_READY  = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: two-flop synchroniser, stability counter and
// rising-edge detect producing a single-cycle press strobe.
module btn_debounce
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_deb;
  logic             r_deb_d;
  logic [CNT_W-1:0] r_cnt;

  // Any cycle where the synchronised level agrees with the accepted level
  // restarts the count, so only an unbroken run of disagreement is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      r_deb_d <= r_deb;
      if (r_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_deb & ~r_deb_d;

endmodule

// File: rtl/operand_entry_ctrl.sv
// Operand entry sequencer: debounced A/B/F buttons capture operands from the
// switch bank, latch the opcode and issue a registered compute strobe.
module operand_entry_ctrl
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_a,
  input  logic              btn_b,
  input  logic              btn_f,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [OP_W-1:0]   op_out,
  output logic              calc_pulse,
  output logic [1:0]        state_out
);

  logic w_press_a;
  logic w_press_b;
  logic w_press_f;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_a), .o_press(w_press_a)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_b), .o_press(w_press_b)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_f (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_f), .o_press(w_press_f)
  );

  state_e            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic              r_calc;

  // Priority A > B > F; a lower-priority press in the same cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_calc  <= 1'b0;
    end else begin
      r_calc <= 1'b0;
      case (r_state)
        S_WAIT_A: begin
          if (w_press_a) begin
            r_a     <= sw;
            r_state <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (w_press_a) begin
            r_a <= sw;
          end else if (w_press_b) begin
            r_b     <= sw;
            r_state <= S_READY;
          end
        end
        S_READY: begin
          if (w_press_a) begin
            r_a     <= sw;
            r_state <= S_WAIT_B;
          end else if (w_press_b) begin
            r_b <= sw;
          end else if (w_press_f) begin
            r_op   <= sw[OP_W-1:0];
            r_calc <= 1'b1;
          end
        end
        default: r_state <= S_WAIT_A;
      endcase
    end
  end

  assign a_out      = r_a;
  assign b_out      = r_b;
  assign op_out     = r_op;
  assign calc_pulse = r_calc;
  assign state_out  = r_state;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Scoreboard bench for operand_entry_ctrl with DEBOUNCE_CYCLES=4: stimulus
// queues expected output changes, a negedge monitor pops and compares them.
module tb_operand_entry_ctrl;

  logic        clk;
  logic        rst_n;
  logic        btn_a;
  logic        btn_b;
  logic        btn_f;
  logic [31:0] sw;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [3:0]  op_out;
  logic        calc_pulse;
  logic [1:0]  state_out;

  operand_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_a(btn_a), .btn_b(btn_b), .btn_f(btn_f),
    .sw(sw), .a_out(a_out), .b_out(b_out), .op_out(op_out),
    .calc_pulse(calc_pulse), .state_out(state_out)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        cp;
    logic [1:0]  st;
    int          cyc;
  } expT;

  expT expQ[$];
  int  cyc        = 0;
  int  checkCount = 0;
  int  passCount  = 0;
  logic [70:0] prevOut = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any change on the outputs must match the next queued expectation.
  always @(negedge clk) begin
    logic [70:0] curOut;
    expT e;
    curOut = {a_out, b_out, op_out, calc_pulse, state_out};
    if (curOut !== prevOut) begin
      checkCount++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpectedChange: got a=%h b=%h op=%h cp=%b st=%0d at cyc %0d, required no change",
                 a_out, b_out, op_out, calc_pulse, state_out, cyc);
      end else begin
        e = expQ.pop_front();
        if (a_out !== e.a || b_out !== e.b || op_out !== e.op || calc_pulse !== e.cp ||
            state_out !== e.st || (e.cyc >= 0 && cyc != e.cyc)) begin
          $display("[TB] FAIL %s: got a=%h b=%h op=%h cp=%b st=%0d cyc=%0d, required a=%h b=%h op=%h cp=%b st=%0d cyc=%0d",
                   e.name, a_out, b_out, op_out, calc_pulse, state_out, cyc,
                   e.a, e.b, e.op, e.cp, e.st, e.cyc);
        end else begin
          passCount++;
        end
      end
      prevOut = curOut;
    end
  end

  task automatic expectEvent(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op, input logic cp, input logic [1:0] st,
                             input int atCyc);
    expT e;
    e.name = name; e.a = a; e.b = b; e.op = op; e.cp = cp; e.st = st; e.cyc = atCyc;
    expQ.push_back(e);
  endtask

  // Raises the selected buttons {a,b,f} right after a negedge; the next posedge is edge 1.
  task automatic applyStimulus(input logic [2:0] btns, input logic [31:0] swVal,
                               output int startCyc);
    @(negedge clk);
    sw = swVal;
    {btn_a, btn_b, btn_f} = btns;
    startCyc = cyc;
  endtask

  task automatic releaseAfter(input int hold);
    repeat (hold) @(negedge clk);
    {btn_a, btn_b, btn_f} = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op, input logic cp, input logic [1:0] st);
    checkCount++;
    if (a_out !== a || b_out !== b || op_out !== op || calc_pulse !== cp || state_out !== st)
      $display("[TB] FAIL %s: got a=%h b=%h op=%h cp=%b st=%0d, required a=%h b=%h op=%h cp=%b st=%0d",
               name, a_out, b_out, op_out, calc_pulse, state_out, a, b, op, cp, st);
    else
      passCount++;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL %s: %0d expected events still pending, required 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b1;
    {btn_a, btn_b, btn_f} = 3'b000;
    sw = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetState", 32'h0, 32'h0, 4'h0, 1'b0, 2'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic sequence");
    applyStimulus(3'b100, 32'h0000_0012, c);
    expectEvent("loadA", 32'h12, 32'h0, 4'h0, 1'b0, 2'd1, c + 7);
    releaseAfter(10);
    applyStimulus(3'b010, 32'h0000_0034, c);
    expectEvent("loadB", 32'h12, 32'h34, 4'h0, 1'b0, 2'd2, c + 7);
    releaseAfter(10);
    applyStimulus(3'b001, 32'h0000_0005, c);
    expectEvent("calcRise", 32'h12, 32'h34, 4'h5, 1'b1, 2'd2, c + 7);
    expectEvent("calcFall", 32'h12, 32'h34, 4'h5, 1'b0, 2'd2, c + 8);
    releaseAfter(10);
    waitDrain("basicDrain");
    sw = 32'hDEAD_BEEF;
    repeat (10) @(negedge clk);

    $display("[TB] bounce filtering");
    sw = 32'h0000_ABCD;
    for (int i = 0; i < 5; i++) begin
      btn_a = 1'b1;
      repeat (2) @(negedge clk);
      btn_a = 1'b0;
      repeat (2) @(negedge clk);
    end
    applyStimulus(3'b100, 32'h0000_ABCD, c);
    expectEvent("bounceLoadA", 32'hABCD, 32'h34, 4'h5, 1'b0, 2'd1, c + 7);
    releaseAfter(10);
    applyStimulus(3'b010, 32'h0000_0077, c);
    expectEvent("reloadB", 32'hABCD, 32'h77, 4'h5, 1'b0, 2'd2, c + 7);
    releaseAfter(10);
    waitDrain("bounceDrain");

    $display("[TB] simultaneous A and F");
    applyStimulus(3'b101, 32'h0000_0099, c);
    expectEvent("simulA", 32'h99, 32'h77, 4'h5, 1'b0, 2'd1, c + 7);
    releaseAfter(10);
    applyStimulus(3'b010, 32'h0000_0056, c);
    expectEvent("simulB", 32'h99, 32'h56, 4'h5, 1'b0, 2'd2, c + 7);
    releaseAfter(10);
    waitDrain("simulDrain");

    $display("[TB] held F");
    applyStimulus(3'b001, 32'h0000_0003, c);
    expectEvent("heldCalcRise", 32'h99, 32'h56, 4'h3, 1'b1, 2'd2, c + 7);
    expectEvent("heldCalcFall", 32'h99, 32'h56, 4'h3, 1'b0, 2'd2, c + 8);
    releaseAfter(100);
    applyStimulus(3'b001, 32'h0000_000A, c);
    expectEvent("repressRise", 32'h99, 32'h56, 4'hA, 1'b1, 2'd2, c + 7);
    expectEvent("repressFall", 32'h99, 32'h56, 4'hA, 1'b0, 2'd2, c + 8);
    releaseAfter(10);
    waitDrain("heldDrain");

    $display("[TB] reset mid-debounce");
    applyStimulus(3'b100, 32'h0000_0011, c);
    expectEvent("loadA2", 32'h11, 32'h56, 4'hA, 1'b0, 2'd1, c + 7);
    releaseAfter(10);
    waitDrain("preResetDrain");
    applyStimulus(3'b010, 32'h0000_0022, c);
    repeat (3) @(negedge clk);
    expectEvent("resetAsync", 32'h0, 32'h0, 4'h0, 1'b0, 2'd0, -1);
    #2 rst_n = 1'b0;
    #1 checkOutput("resetImmediate", 32'h0, 32'h0, 4'h0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    releaseAfter(20);
    waitDrain("resetDrain");

    $display("[TB] illegal order");
    applyStimulus(3'b010, 32'h0000_0044, c);
    releaseAfter(10);
    applyStimulus(3'b001, 32'h0000_0005, c);
    releaseAfter(10);
    checkOutput("illegalOrder", 32'h0, 32'h0, 4'h0, 1'b0, 2'd0);
    applyStimulus(3'b100, 32'h0000_0066, c);
    expectEvent("loadAAfterReset", 32'h66, 32'h0, 4'h0, 1'b0, 2'd1, c + 7);
    releaseAfter(10);
    waitDrain("finalDrain");

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
